// File: rtl/image_frame_loader.sv
// Byte-stream to image/label assembler feeding cnn_top; holds the frame until cnn_done.
// Define FRAME_SYNC_EN to require a SYNC_BYTE header before every record.
module image_frame_loader #(
  parameter int              NUM_PIXELS = 784,
  parameter int              PIX_W      = 8,
  parameter logic [PIX_W-1:0] SYNC_BYTE = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PIX_W-1:0]            in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [PIX_W*NUM_PIXELS-1:0] image_data,
  output logic [PIX_W-1:0]            label,
  output logic                        start,
  input  logic                        cnn_done,
  output logic                        busy,
  output logic [15:0]                 frame_count
);
  localparam int IDX_W = $clog2(NUM_PIXELS+1);

  typedef enum logic [1:0] {SYNC, LOAD, START, WAIT_DONE} state_t;

`ifdef FRAME_SYNC_EN
  localparam state_t HOME = SYNC;
`else
  localparam state_t HOME = LOAD;
`endif

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             xfer;

  // Decoded from state only, so no in_valid -> in_ready path exists.
  assign in_ready = (state == LOAD) || (state == SYNC);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HOME;
      idx         <= '0;
      image_data  <= '0;
      label       <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        SYNC: begin
          if (xfer && in_data == SYNC_BYTE) begin
            state <= LOAD;
            idx   <= '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            if (idx == IDX_W'(NUM_PIXELS)) begin
              label <= in_data;
              idx   <= '0;
              state <= START;
              start <= 1'b1;
              busy  <= 1'b1;
            end else begin
              image_data[int'(idx)*PIX_W +: PIX_W] <= in_data;
              idx <= idx + 1'b1;
            end
          end
        end
        START: begin
          start <= 1'b0;
          if (cnn_done) begin
            frame_count <= frame_count + 16'd1;
            busy        <= 1'b0;
            state       <= HOME;
          end else begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (cnn_done) begin
            frame_count <= frame_count + 16'd1;
            busy        <= 1'b0;
            state       <= HOME;
          end
        end
        default: state <= HOME;
      endcase
    end
  end
endmodule

// File: tb/tb_image_frame_loader.sv
// Directed bench for image_frame_loader; inputs driven and outputs checked 1ns after rising edges.
module tb_image_frame_loader;
  localparam int NP = 784;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NP*PW-1:0] image_data;
  logic [PW-1:0] label;
  logic          start;
  logic          cnn_done = 1'b0;
  logic          busy;
  logic [15:0]   frame_count;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  int cyc = 0;
  int fc_exp = 0;
  logic [7:0] exp_pix [NP];

  image_frame_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .image_data(image_data), .label(label), .start(start), .cnn_done(cnn_done),
    .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (start) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
  endtask

  function automatic logic [7:0] pix_val(input int mode, input int k);
    case (mode)
      0:       return 8'(k % 256);
      1:       return 8'(255 - (k % 256));
      default: return 8'((k * 3) % 256);
    endcase
  endfunction

  function automatic int pix_err();
    int e = 0;
    for (int k = 0; k < NP; k++)
      if (image_data[k*PW +: PW] !== exp_pix[k]) e++;
    return e;
  endfunction

  // Presents one byte (optionally after an idle gap cycle) and returns after it transfers.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) begin
      in_valid = 1'b0; in_data = 8'hEE;
      tick();
    end
    in_valid = 1'b1; in_data = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("ready_timeout", n, 0);
    tick();
  endtask

  task automatic send_pixels(input int mode, input int from, input int to, input bit gap);
    for (int k = from; k < to; k++) begin
      exp_pix[k] = pix_val(mode, k);
      send_byte(exp_pix[k], gap);
    end
  endtask

  task automatic send_record(input int mode, input logic [7:0] lab, input bit gap);
`ifdef FRAME_SYNC_EN
    send_byte(8'hA5, gap);
`endif
    send_pixels(mode, 0, NP, gap);
    send_byte(lab, gap);
  endtask

  task automatic done_pulse();
    in_valid = 1'b0;
    cnn_done = 1'b1;
    tick();
    cnn_done = 1'b0;
    fc_exp++;
  endtask

  initial begin
    int s0, c0;
    tick(); tick();
    chk("rst_ready", in_ready, 1);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_label", label, 0);
    chk("rst_img", (image_data == '0), 1);
    rst = 1'b0;

    // 1: back-to-back record, label 7
    s0 = start_cnt; c0 = cyc;
`ifdef FRAME_SYNC_EN
    send_byte(8'hA5, 1'b0); c0 = cyc;
`endif
    send_pixels(0, 0, NP, 1'b0);
    send_byte(8'd7, 1'b0);
    chk("t1_cycles", cyc - c0, NP + 1);
    chk("t1_start", start, 1);
    chk("t1_busy", busy, 1);
    chk("t1_ready", in_ready, 0);
    chk("t1_label", label, 7);
    chk("t1_pix", pix_err(), 0);
    tick();
    chk("t1_start_low", start, 0);
    chk("t1_one_start", start_cnt - s0, 1);
    done_pulse();
    chk("t1_fc", frame_count, fc_exp);

    // 2: gapped stream, different pixel pattern so stale/dup bytes show up
    s0 = start_cnt;
    send_record(1, 8'd7, 1'b1);
    chk("t2_start", start, 1);
    chk("t2_label", label, 7);
    chk("t2_pix", pix_err(), 0);

    // 3: input held valid while waiting for cnn_done
    in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      chk("t3_ready_low", in_ready, 0);
      tick();
    end
    chk("t2_one_start", start_cnt - s0, 1);
    chk("t3_pix_hold", pix_err(), 0);
    chk("t3_label_hold", label, 7);
    cnn_done = 1'b1;
    tick();
    cnn_done = 1'b0;
    fc_exp++;
    chk("t3_ready", in_ready, 1);
    chk("t3_fc", frame_count, fc_exp);
    tick();
`ifdef FRAME_SYNC_EN
    chk("t3_sync_drop", pix_err(), 0);
    send_record(0, 8'd5, 1'b0);
`else
    exp_pix[0] = 8'h55;
    chk("t3_pix0", pix_err(), 0);
    send_pixels(0, 1, NP, 1'b0);
    send_byte(8'd5, 1'b0);
`endif
    chk("t3_label", label, 5);
    chk("t3_pix_all", pix_err(), 0);

    // 4: cnn_done already high in the START cycle
    chk("t4_start", start, 1);
    in_valid = 1'b0;
    cnn_done = 1'b1;
    tick();
    cnn_done = 1'b0;
    fc_exp++;
    chk("t4_ready", in_ready, 1);
    chk("t4_busy", busy, 0);
    chk("t4_fc", frame_count, fc_exp);

    // 5: reset mid-record (cnn_done high too: reset wins)
`ifdef FRAME_SYNC_EN
    send_byte(8'hA5, 1'b0);
`endif
    send_pixels(2, 0, 300, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1; cnn_done = 1'b1;
    tick();
    rst = 1'b0; cnn_done = 1'b0;
    fc_exp = 0;
    chk("t5_img", (image_data == '0), 1);
    chk("t5_label", label, 0);
    chk("t5_start", start, 0);
    chk("t5_busy", busy, 0);
    chk("t5_fc", frame_count, 0);
    chk("t5_ready", in_ready, 1);
    s0 = start_cnt;
    send_record(2, 8'd3, 1'b0);
    chk("t5_label3", label, 3);
    chk("t5_pix", pix_err(), 0);
    tick();
    chk("t5_one_start", start_cnt - s0, 1);
    done_pulse();
    chk("t5_fc", frame_count, fc_exp);

`ifdef FRAME_SYNC_EN
    // 6: junk bytes before the header are discarded
    send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b0);
    s0 = start_cnt;
    send_record(1, 8'd4, 1'b0);
    chk("t6_start", start, 1);
    chk("t6_label", label, 4);
    chk("t6_pix", pix_err(), 0);
    tick();
    done_pulse();
    chk("t6_ready", in_ready, 1);
    send_byte(8'h33, 1'b0);
    chk("t6_in_sync", pix_err(), 0);
    chk("t6_one_start", start_cnt - s0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
